// File: rtl/nios_system_sysid_arb.sv
// Two-master read arbiter in front of a shared, combinational system-ID slave.
// Define SYSID_ARB_RR_EN for round-robin tie-breaking; otherwise master 0 always wins ties.
module nios_system_sysid_arb #(
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset_n,

    input  logic              m0_read,
    input  logic              m0_address,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,

    input  logic              m1_read,
    input  logic              m1_address,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,

    output logic              sysid_address,
    input  logic [DATA_W-1:0] sysid_readdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_e;

    state_e            state_q, state_d;
    state_e            tie_grant;
    logic [DATA_W-1:0] m0_readdata_q, m0_readdata_d;
    logic [DATA_W-1:0] m1_readdata_q, m1_readdata_d;
    logic              m0_valid_q, m0_valid_d;
    logic              m1_valid_q, m1_valid_d;

`ifdef SYSID_ARB_RR_EN
    // 0 = master 0 was granted last, 1 = master 1 was granted last.
    logic              last_grant_q, last_grant_d;

    always_comb begin
        tie_grant = (last_grant_q == 1'b0) ? GRANT1 : GRANT0;
    end
`else
    always_comb begin
        tie_grant = GRANT0;
    end
`endif

    // Each grant lasts exactly one cycle; the slave is combinational, so the
    // data is captured on the grant cycle and presented as a one-cycle pulse.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the case leaves it unassigned and no latch is inferred.
        state_d       = state_q;
        m0_readdata_d = m0_readdata_q;
        m1_readdata_d = m1_readdata_q;
        m0_valid_d    = 1'b0;
        m1_valid_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (m0_read && m1_read) begin
                    state_d = tie_grant;
                end else if (m0_read) begin
                    state_d = GRANT0;
                end else if (m1_read) begin
                    state_d = GRANT1;
                end
            end
            GRANT0: begin
                state_d = IDLE;
                if (m0_read) begin
                    m0_readdata_d = sysid_readdata;
                    m0_valid_d    = 1'b1;
                end
            end
            GRANT1: begin
                state_d = IDLE;
                if (m1_read) begin
                    m1_readdata_d = sysid_readdata;
                    m1_valid_d    = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef SYSID_ARB_RR_EN
    always_comb begin
        last_grant_d = last_grant_q;
        if (state_q == IDLE && state_d == GRANT0) begin
            last_grant_d = 1'b0;
        end else if (state_q == IDLE && state_d == GRANT1) begin
            last_grant_d = 1'b1;
        end
    end
`endif

    always_comb begin
        m0_waitrequest = (state_q != GRANT0);
        m1_waitrequest = (state_q != GRANT1);
        case (state_q)
            GRANT0:  sysid_address = m0_address;
            GRANT1:  sysid_address = m1_address;
            default: sysid_address = 1'b0;
        endcase
    end

    // Reset is synchronous: a reset edge during a grant drops the pending
    // capture, so the aborted transfer never produces a valid pulse.
    always_ff @(posedge clock) begin
        // NOTE: state registers use non-blocking assignment so every flop
        // samples the pre-edge values regardless of statement order.
        if (!reset_n) begin
            state_q       <= IDLE;
            m0_readdata_q <= '0;
            m1_readdata_q <= '0;
            m0_valid_q    <= 1'b0;
            m1_valid_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            m0_readdata_q <= m0_readdata_d;
            m1_readdata_q <= m1_readdata_d;
            m0_valid_q    <= m0_valid_d;
            m1_valid_q    <= m1_valid_d;
        end
    end

`ifdef SYSID_ARB_RR_EN
    // Reset to 1 so master 0 wins the first tie.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`endif

    assign m0_readdata      = m0_readdata_q;
    assign m1_readdata      = m1_readdata_q;
    assign m0_readdatavalid = m0_valid_q;
    assign m1_readdatavalid = m1_valid_q;

endmodule

// File: tb/tb_nios_system_sysid_arb.sv
// Self-checking bench for nios_system_sysid_arb: directed scenarios plus a
// randomized run scored against a transaction-level reference model.
module tb_nios_system_sysid_arb;

    localparam int                DATA_W  = 32;
    localparam logic [DATA_W-1:0] ID_WORD = 32'h581799E4;

    logic              clock   = 1'b0;
    logic              reset_n = 1'b0;
    logic              m0_read = 1'b0, m0_address = 1'b0;
    logic              m1_read = 1'b0, m1_address = 1'b0;
    logic              m0_waitrequest, m1_waitrequest;
    logic              m0_readdatavalid, m1_readdatavalid;
    logic [DATA_W-1:0] m0_readdata, m1_readdata;
    logic              sysid_address;
    logic [DATA_W-1:0] sysid_readdata;

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct packed {
        logic              who;
        logic [DATA_W-1:0] data;
    } txn_t;

    nios_system_sysid_arb #(.DATA_W(DATA_W)) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .m0_read          (m0_read),
        .m0_address       (m0_address),
        .m0_waitrequest   (m0_waitrequest),
        .m0_readdata      (m0_readdata),
        .m0_readdatavalid (m0_readdatavalid),
        .m1_read          (m1_read),
        .m1_address       (m1_address),
        .m1_waitrequest   (m1_waitrequest),
        .m1_readdata      (m1_readdata),
        .m1_readdatavalid (m1_readdatavalid),
        .sysid_address    (sysid_address),
        .sysid_readdata   (sysid_readdata)
    );

    function automatic logic [DATA_W-1:0] slave_word(input logic a);
        return a ? ID_WORD : '0;
    endfunction

    // Shared slave: address 0 reads zero, address 1 reads the ID word.
    assign sysid_readdata = slave_word(sysid_address);

    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset;
        reset_n = 1'b0;
        m0_read = 1'b0;
        m1_read = 1'b0;
        tick;
        tick;
        reset_n = 1'b1;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        tick;
        tick;
        n_vec++; if (m0_waitrequest !== 1'b1) begin n_miss++; $display("FAIL reset_m0_wait got %b want 1", m0_waitrequest); end
        n_vec++; if (m1_waitrequest !== 1'b1) begin n_miss++; $display("FAIL reset_m1_wait got %b want 1", m1_waitrequest); end
        n_vec++; if (sysid_address !== 1'b0) begin n_miss++; $display("FAIL reset_sysid_addr got %b want 0", sysid_address); end
        n_vec++; if (m0_readdatavalid !== 1'b0) begin n_miss++; $display("FAIL reset_m0_valid got %b want 0", m0_readdatavalid); end
        n_vec++; if (m1_readdatavalid !== 1'b0) begin n_miss++; $display("FAIL reset_m1_valid got %b want 0", m1_readdatavalid); end
        n_vec++; if (m0_readdata !== '0) begin n_miss++; $display("FAIL reset_m0_data got %h want 0", m0_readdata); end
        n_vec++; if (m1_readdata !== '0) begin n_miss++; $display("FAIL reset_m1_data got %h want 0", m1_readdata); end
        reset_n = 1'b1;
    endtask

    task automatic test_single_read;
        do_reset;
        m0_read    = 1'b1;
        m0_address = 1'b1;
        tick;
        n_vec++; if (m0_waitrequest !== 1'b0) begin n_miss++; $display("FAIL single_m0_wait got %b want 0", m0_waitrequest); end
        n_vec++; if (m1_waitrequest !== 1'b1) begin n_miss++; $display("FAIL single_m1_wait got %b want 1", m1_waitrequest); end
        n_vec++; if (sysid_address !== 1'b1) begin n_miss++; $display("FAIL single_sysid_addr got %b want 1", sysid_address); end
        tick;
        m0_read = 1'b0;
        n_vec++; if (m0_readdatavalid !== 1'b1) begin n_miss++; $display("FAIL single_m0_valid got %b want 1", m0_readdatavalid); end
        n_vec++; if (m0_readdata !== ID_WORD) begin n_miss++; $display("FAIL single_m0_data got %h want %h", m0_readdata, ID_WORD); end
        n_vec++; if (m1_readdatavalid !== 1'b0) begin n_miss++; $display("FAIL single_m1_valid got %b want 0", m1_readdatavalid); end
        n_vec++; if (m1_readdata !== '0) begin n_miss++; $display("FAIL single_m1_data got %h want 0", m1_readdata); end
        tick;
        n_vec++; if (m0_readdatavalid !== 1'b0) begin n_miss++; $display("FAIL single_valid_pulse got %b want 0", m0_readdatavalid); end
        n_vec++; if (m0_readdata !== ID_WORD) begin n_miss++; $display("FAIL single_data_hold got %h want %h", m0_readdata, ID_WORD); end
    endtask

    task automatic test_contention;
        int g;
        int pg;
        pg = 0;
        do_reset;
        m0_read = 1'b1; m0_address = 1'b1;
        m1_read = 1'b1; m1_address = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick;
            g = 0;
            if (i % 2 == 1) begin
`ifdef SYSID_ARB_RR_EN
                g = ((i / 2) % 2 == 0) ? 1 : 2;
`else
                g = 1;
`endif
            end
            n_vec++; if (m0_waitrequest !== (g != 1)) begin n_miss++; $display("FAIL tie_m0_wait cyc %0d got %b want %b", i, m0_waitrequest, g != 1); end
            n_vec++; if (m1_waitrequest !== (g != 2)) begin n_miss++; $display("FAIL tie_m1_wait cyc %0d got %b want %b", i, m1_waitrequest, g != 2); end
            n_vec++; if (sysid_address !== (g == 1)) begin n_miss++; $display("FAIL tie_sysid_addr cyc %0d got %b want %b", i, sysid_address, g == 1); end
            n_vec++; if (m0_readdatavalid !== (pg == 1)) begin n_miss++; $display("FAIL tie_m0_valid cyc %0d got %b want %b", i, m0_readdatavalid, pg == 1); end
            n_vec++; if (m1_readdatavalid !== (pg == 2)) begin n_miss++; $display("FAIL tie_m1_valid cyc %0d got %b want %b", i, m1_readdatavalid, pg == 2); end
            if (pg == 1) begin
                n_vec++; if (m0_readdata !== ID_WORD) begin n_miss++; $display("FAIL tie_m0_data cyc %0d got %h want %h", i, m0_readdata, ID_WORD); end
            end
            if (pg == 2) begin
                n_vec++; if (m1_readdata !== '0) begin n_miss++; $display("FAIL tie_m1_data cyc %0d got %h want 0", i, m1_readdata); end
            end
            pg = g;
        end
        m0_read = 1'b0;
        m1_read = 1'b0;
        tick;
    endtask

    task automatic test_withdraw;
        m1_read = 1'b1; m1_address = 1'b1;
        tick;
        tick;
        m1_read = 1'b0;
        n_vec++; if (m1_readdata !== ID_WORD) begin n_miss++; $display("FAIL wd_setup_data got %h want %h", m1_readdata, ID_WORD); end
        tick;
        m1_read = 1'b1; m1_address = 1'b0;
        tick;
        n_vec++; if (m1_waitrequest !== 1'b0) begin n_miss++; $display("FAIL wd_grant got %b want 0", m1_waitrequest); end
        m1_read = 1'b0;
        tick;
        n_vec++; if (m1_readdatavalid !== 1'b0) begin n_miss++; $display("FAIL wd_valid got %b want 0", m1_readdatavalid); end
        n_vec++; if (m1_readdata !== ID_WORD) begin n_miss++; $display("FAIL wd_data_hold got %h want %h", m1_readdata, ID_WORD); end
        n_vec++; if (m1_waitrequest !== 1'b1 || m0_waitrequest !== 1'b1) begin n_miss++; $display("FAIL wd_idle wait got %b%b want 11", m0_waitrequest, m1_waitrequest); end
        tick;
        n_vec++; if (m1_readdatavalid !== 1'b0) begin n_miss++; $display("FAIL wd_late_valid got %b want 0", m1_readdatavalid); end
    endtask

    task automatic test_reset_abort;
        m0_read = 1'b1; m0_address = 1'b1;
        tick;
        tick;
        m0_read = 1'b0;
        n_vec++; if (m0_readdata !== ID_WORD) begin n_miss++; $display("FAIL abort_setup_data got %h want %h", m0_readdata, ID_WORD); end
        tick;
        m0_read = 1'b1;
        tick;
        n_vec++; if (m0_waitrequest !== 1'b0) begin n_miss++; $display("FAIL abort_grant got %b want 0", m0_waitrequest); end
        reset_n = 1'b0;
        tick;
        n_vec++; if (m0_readdatavalid !== 1'b0) begin n_miss++; $display("FAIL abort_valid got %b want 0", m0_readdatavalid); end
        n_vec++; if (m0_readdata !== '0) begin n_miss++; $display("FAIL abort_data got %h want 0", m0_readdata); end
        n_vec++; if (m0_waitrequest !== 1'b1 || m1_waitrequest !== 1'b1) begin n_miss++; $display("FAIL abort_wait got %b%b want 11", m0_waitrequest, m1_waitrequest); end
        reset_n = 1'b1;
        m0_read = 1'b0;
        tick;
        n_vec++; if (m0_readdatavalid !== 1'b0) begin n_miss++; $display("FAIL abort_late_valid got %b want 0", m0_readdatavalid); end
    endtask

    // Reference model: a granted master owns the slave for one cycle, after
    // which the slave is free for one cycle; the data from a completed grant
    // appears the cycle after. A separate FIFO scoreboard checks that every
    // accepted read returns exactly one valid with the right word.
    task automatic test_random;
        int                grant;
        logic              ev [2];
        logic [DATA_W-1:0] ed [2];
        logic              r [2];
        logic              a [2];
        logic              w [2];
        logic              v [2];
        logic [DATA_W-1:0] d [2];
        logic              acc [2];
        logic              exp_sa;
        txn_t              sb [$];
        txn_t              t;
`ifdef SYSID_ARB_RR_EN
        int                last;
        last = 1;
`endif
        grant = 0;
        for (int k = 0; k < 2; k++) begin
            ev[k] = 1'b0; ed[k] = '0; r[k] = 1'b0; a[k] = 1'b0; acc[k] = 1'b0;
        end
        do_reset;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            tick;
            w[0] = m0_waitrequest;   w[1] = m1_waitrequest;
            v[0] = m0_readdatavalid; v[1] = m1_readdatavalid;
            d[0] = m0_readdata;      d[1] = m1_readdata;
            for (int k = 0; k < 2; k++) begin
                n_vec++; if (w[k] !== (grant != k + 1)) begin n_miss++; $display("FAIL rnd_wait m%0d cyc %0d got %b want %b", k, cyc, w[k], grant != k + 1); end
                n_vec++; if (v[k] !== ev[k]) begin n_miss++; $display("FAIL rnd_valid m%0d cyc %0d got %b want %b", k, cyc, v[k], ev[k]); end
                n_vec++; if (d[k] !== ed[k]) begin n_miss++; $display("FAIL rnd_data m%0d cyc %0d got %h want %h", k, cyc, d[k], ed[k]); end
                if (v[k] === 1'b1) begin
                    n_vec++;
                    if (sb.size() == 0) begin
                        n_miss++; $display("FAIL rnd_sb_extra m%0d cyc %0d got valid want none", k, cyc);
                    end else begin
                        t = sb.pop_front();
                        if (t.who !== 1'(k) || t.data !== d[k]) begin
                            n_miss++; $display("FAIL rnd_sb m%0d cyc %0d got %h want m%0d %h", k, cyc, d[k], t.who, t.data);
                        end
                    end
                end
            end
            n_vec++; if ((v[0] & v[1]) !== 1'b0) begin n_miss++; $display("FAIL rnd_coincide cyc %0d got %b%b want not 11", cyc, v[0], v[1]); end

            for (int k = 0; k < 2; k++) begin
                if (!w[k]) begin
                    if ($urandom % 16 == 0) r[k] = 1'b0;
                    acc[k] = r[k];
                end else if (r[k] && !acc[k]) begin
                    if ($urandom % 32 == 0) r[k] = 1'b0;
                end else begin
                    r[k]   = ($urandom % 2) == 1;
                    a[k]   = ($urandom % 2) == 1;
                    acc[k] = 1'b0;
                end
            end
            m0_read = r[0]; m0_address = a[0];
            m1_read = r[1]; m1_address = a[1];
            #1;
            exp_sa = (grant == 1) ? a[0] : (grant == 2) ? a[1] : 1'b0;
            n_vec++; if (sysid_address !== exp_sa) begin n_miss++; $display("FAIL rnd_sysid_addr cyc %0d got %b want %b", cyc, sysid_address, exp_sa); end
            for (int k = 0; k < 2; k++) begin
                if (!w[k] && r[k]) sb.push_back('{who: 1'(k), data: slave_word(a[k])});
            end

            for (int k = 0; k < 2; k++) begin
                ev[k] = (grant == k + 1) && r[k];
                if (ev[k]) ed[k] = slave_word(a[k]);
            end
            if (grant != 0) begin
                grant = 0;
            end else if (r[0] && r[1]) begin
`ifdef SYSID_ARB_RR_EN
                grant = (last == 0) ? 2 : 1;
`else
                grant = 1;
`endif
            end else if (r[0]) begin
                grant = 1;
            end else if (r[1]) begin
                grant = 2;
            end
`ifdef SYSID_ARB_RR_EN
            if (grant == 1) last = 0;
            if (grant == 2) last = 1;
`endif
        end
        tick;
        v[0] = m0_readdatavalid; v[1] = m1_readdatavalid;
        d[0] = m0_readdata;      d[1] = m1_readdata;
        for (int k = 0; k < 2; k++) begin
            n_vec++; if (v[k] !== ev[k]) begin n_miss++; $display("FAIL rnd_drain_valid m%0d got %b want %b", k, v[k], ev[k]); end
            if (v[k] === 1'b1 && sb.size() != 0) t = sb.pop_front();
        end
        m0_read = 1'b0;
        m1_read = 1'b0;
        n_vec++; if (sb.size() != 0) begin n_miss++; $display("FAIL rnd_sb_lost got %0d pending want 0", sb.size()); end
        tick;
    endtask

    initial begin
        test_reset;
        test_single_read;
        test_contention;
        test_withdraw;
        test_reset_abort;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
